latency_line_memory: RTL and testbench
======================================

Name: latency_line_memory

Overview:
- Parametrised successor to the team's two-port, fixed-latency line memory: port 1 is a read-only instruction fetch port, port 2 is a read/write data port.
- Configurable word width, depth, line size and access latency.
- Explicit ready/valid handshakes with a per-port busy FSM replace free-running counters.
- Separate read/write data buses replace the bidirectional bus; word and full-line writes supported.
- Sits between the CPU cache controllers and the simulation memory model.

Parameters:
- WORD_SIZE, 16, bits per word.
- ADDR_WIDTH, 16, word-address width on both ports.
- DEPTH_LOG2, 8, log2 of words stored (256 words); upper address bits ignored (wrap).
- WORDS_PER_LINE, 4, words per line; power of 2, >=2.
- LATENCY, 5, cycles from request acceptance to completion; >=1.

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- req1  input  1  port-1 line read request
- addr1  input  ADDR_WIDTH  port-1 word address (low log2(WORDS_PER_LINE) bits ignored)
- ready1  output  1  port 1 idle, may accept req1
- valid1  output  1  one-cycle pulse, rdata1 valid
- rdata1  output  WORD_SIZE*WORDS_PER_LINE  line, word 0 in LSBs
- req2  input  1  port-2 request
- we2  input  1  1 = write, 0 = line read
- line_we2  input  1  with we2: 1 = write whole line, 0 = single word at addr2
- addr2  input  ADDR_WIDTH  port-2 word address
- wdata2  input  WORD_SIZE*WORDS_PER_LINE  write data; word write uses bits [WORD_SIZE-1:0]
- ready2  output  1  port 2 idle
- valid2  output  1  one-cycle pulse: read data valid or write committed
- rdata2  output  WORD_SIZE*WORDS_PER_LINE  port-2 read line

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous and active-low.
- Reset values: ready1=ready2=1; valid1=valid2=0; rdata1=rdata2=0; both FSMs IDLE.
- Reset does not clear the array; contents persist across reset.
- Each port has an independent FSM, IDLE -> BUSY -> IDLE, plus a latency counter of width clog2(LATENCY+1).
- IDLE: ready=1. If req is sampled high at edge T:
  - latch addr/we/line_we/wdata;
  - load counter with LATENCY-1;
  - go to BUSY.
- BUSY: ready=0; counter decrements each edge.
  - On the edge where the counter==0: perform the access, pulse valid for exactly one cycle, return to IDLE.
- Timing: request accepted at edge T -> valid high in the cycle following edge T+LATENCY-1.
  - LATENCY=1: valid in the cycle right after acceptance.
  - ready returns high in the same cycle valid is high, so back-to-back acceptance is legal; max throughput is 1 access per LATENCY cycles.
- req while BUSY is ignored; no queueing. Inputs need be stable only at the accepting edge.
- Line address = addr[DEPTH_LOG2-1:log2(WORDS_PER_LINE)]. Word write index = addr[DEPTH_LOG2-1:0]. Higher bits ignored (aliasing wraps).
- Reads: rdata loaded at the completion edge with array contents before that edge's writes; rdata holds until the next completion on that port.
- Writes:
  - word write stores wdata2[WORD_SIZE-1:0] at the indexed word;
  - line write stores all words of the line;
  - commit at the completion edge; rdata2 unchanged on writes.
- Simultaneous completion, port-1 read and port-2 write to the same line: see Optional Feature. Ports never stall each other.
- Reset mid-operation: FSMs to IDLE immediately; in-flight reads produce no valid; an uncommitted write is dropped (array unchanged).

Optional Feature:
- Macro: LATENCY_LINE_MEMORY_FORWARD_EN
- Defined: when port-1 and port-2-write complete at the same edge to the same line, rdata1 returns the merged post-write line (full line, or the single written word substituted).
- Undefined: rdata1 returns the pre-write line contents.
- Port-2 reads never forward in either mode.

Test Plan:
- Reset, then line-write 0x1111,0x2222,0x3333,0x4444 at addr2=0x10; read addr1=0x12 -> valid1 5 cycles after acceptance, rdata1=0x4444_3333_2222_1111; ready1 low for exactly 4 cycles.
- Word write 0xBEEF at addr2=0x21, then port-2 read addr2=0x20 -> rdata2 word1=0xBEEF, other words unchanged; valid2 pulses once per access.
- Hold req1 high continuously -> acceptances exactly every 5 cycles; no valid1 without a prior acceptance; a req1 pulse while busy is ignored.
- Same-edge completion: port-1 read and port-2 word write 0xCAFE to the same line -> rdata1 word shows 0xCAFE with LATENCY_LINE_MEMORY_FORWARD_EN, old value without.
- Assert reset_n low 2 cycles into a write to 0x30 -> no valid2, ready2=1 immediately, later read of 0x30 returns the pre-write value.
- addr1=0x0110 with DEPTH_LOG2=8 -> returns the line at 0x10 (wrap); repeat with LATENCY=1 -> valid1 the cycle after acceptance.

Source files
------------

// File: rtl/latency_line_memory.sv
// Two-port line memory: port 1 reads whole lines, port 2 reads lines or writes words/lines,
// each with a ready/valid handshake and a fixed LATENCY. Optional macro: LATENCY_LINE_MEMORY_FORWARD_EN.
module latency_line_memory #(
    parameter int WORD_SIZE      = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int DEPTH_LOG2     = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int LATENCY        = 5
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                req1,
    input  logic [ADDR_WIDTH-1:0]               addr1,
    output logic                                ready1,
    output logic                                valid1,
    output logic [WORD_SIZE*WORDS_PER_LINE-1:0] rdata1,
    input  logic                                req2,
    input  logic                                we2,
    input  logic                                line_we2,
    input  logic [ADDR_WIDTH-1:0]               addr2,
    input  logic [WORD_SIZE*WORDS_PER_LINE-1:0] wdata2,
    output logic                                ready2,
    output logic                                valid2,
    output logic [WORD_SIZE*WORDS_PER_LINE-1:0] rdata2
);

    localparam int LINE_W    = WORD_SIZE * WORDS_PER_LINE;
    localparam int OFF_W     = $clog2(WORDS_PER_LINE);
    localparam int IDX_W     = DEPTH_LOG2 - OFF_W;
    localparam int NUM_LINES = 1 << IDX_W;
    localparam int CNT_W     = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // With LATENCY=1 the access happens on the accepting edge itself, so BUSY is never entered.
    localparam bit IMMEDIATE = (LATENCY == 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    logic [LINE_W-1:0] mem [NUM_LINES];

    state_t             state1, state1_next;
    logic [CNT_W-1:0]   cnt1, cnt1_next;
    logic               accept1, done1;
    logic [IDX_W-1:0]   line1_q;
    logic [IDX_W-1:0]   acc_line1;

    state_t             state2, state2_next;
    logic [CNT_W-1:0]   cnt2, cnt2_next;
    logic               accept2, done2;
    logic [IDX_W-1:0]   line2_q;
    logic [OFF_W-1:0]   off2_q;
    logic               we2_q, line_we2_q;
    logic [LINE_W-1:0]  wdata2_q;

    logic [IDX_W-1:0]   acc_line2;
    logic [OFF_W-1:0]   acc_off2;
    logic               acc_we2, acc_line_we2;
    logic [LINE_W-1:0]  acc_wdata2;

    logic               wr_en;
    logic [LINE_W-1:0]  merged_line;
    logic [LINE_W-1:0]  wr_data;
    logic               fwd1;
    logic               unused_addr;

    assign unused_addr = ^{addr1, addr2};

    // Port 1 state register and captured line address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state1  <= IDLE;
            cnt1    <= '0;
            line1_q <= '0;
        end else begin
            state1 <= state1_next;
            cnt1   <= cnt1_next;
            if (accept1) begin
                line1_q <= addr1[DEPTH_LOG2-1:OFF_W];
            end
        end
    end

    always_comb begin
        state1_next = state1;
        cnt1_next   = cnt1;
        accept1     = 1'b0;
        done1       = 1'b0;
        case (state1)
            IDLE: begin
                if (req1) begin
                    accept1 = 1'b1;
                    if (IMMEDIATE) begin
                        done1 = 1'b1;
                    end else begin
                        state1_next = BUSY;
                        cnt1_next   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                cnt1_next = cnt1 - CNT_ONE;
                if (cnt1 == CNT_ONE) begin
                    done1       = 1'b1;
                    state1_next = IDLE;
                end
            end
            default: state1_next = IDLE;
        endcase
    end

    assign ready1    = (state1 == IDLE);
    assign acc_line1 = (state1 == IDLE) ? addr1[DEPTH_LOG2-1:OFF_W] : line1_q;

    // Port 2 state register and captured request fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state2     <= IDLE;
            cnt2       <= '0;
            line2_q    <= '0;
            off2_q     <= '0;
            we2_q      <= 1'b0;
            line_we2_q <= 1'b0;
            wdata2_q   <= '0;
        end else begin
            state2 <= state2_next;
            cnt2   <= cnt2_next;
            if (accept2) begin
                line2_q    <= addr2[DEPTH_LOG2-1:OFF_W];
                off2_q     <= addr2[OFF_W-1:0];
                we2_q      <= we2;
                line_we2_q <= line_we2;
                wdata2_q   <= wdata2;
            end
        end
    end

    always_comb begin
        state2_next = state2;
        cnt2_next   = cnt2;
        accept2     = 1'b0;
        done2       = 1'b0;
        case (state2)
            IDLE: begin
                if (req2) begin
                    accept2 = 1'b1;
                    if (IMMEDIATE) begin
                        done2 = 1'b1;
                    end else begin
                        state2_next = BUSY;
                        cnt2_next   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                cnt2_next = cnt2 - CNT_ONE;
                if (cnt2 == CNT_ONE) begin
                    done2       = 1'b1;
                    state2_next = IDLE;
                end
            end
            default: state2_next = IDLE;
        endcase
    end

    assign ready2 = (state2 == IDLE);

    // An access completing straight out of IDLE uses the live inputs, otherwise the captured ones.
    always_comb begin
        acc_line2    = line2_q;
        acc_off2     = off2_q;
        acc_we2      = we2_q;
        acc_line_we2 = line_we2_q;
        acc_wdata2   = wdata2_q;
        if (state2 == IDLE) begin
            acc_line2    = addr2[DEPTH_LOG2-1:OFF_W];
            acc_off2     = addr2[OFF_W-1:0];
            acc_we2      = we2;
            acc_line_we2 = line_we2;
            acc_wdata2   = wdata2;
        end
    end

    // Gating with reset_n keeps a zero-latency write from landing while reset is held.
    assign wr_en = done2 && acc_we2 && reset_n;

    always_comb begin
        merged_line = mem[acc_line2];
        merged_line[int'(acc_off2)*WORD_SIZE +: WORD_SIZE] = acc_wdata2[WORD_SIZE-1:0];
        wr_data = acc_line_we2 ? acc_wdata2 : merged_line;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[acc_line2] <= wr_data;
        end
    end

`ifdef LATENCY_LINE_MEMORY_FORWARD_EN
    assign fwd1 = wr_en && (acc_line1 == acc_line2);
`else
    assign fwd1 = 1'b0;
`endif

    // Read data is registered at completion and held until the next completion on that port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid1 <= 1'b0;
            rdata1 <= '0;
        end else begin
            valid1 <= done1;
            if (done1) begin
                rdata1 <= fwd1 ? wr_data : mem[acc_line1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid2 <= 1'b0;
            rdata2 <= '0;
        end else begin
            valid2 <= done2;
            if (done2 && !acc_we2) begin
                rdata2 <= mem[acc_line2];
            end
        end
    end

endmodule

// File: tb/tb_latency_line_memory.sv
// Self-checking bench for latency_line_memory: vector table, corner-case sequences and
// randomized traffic against a word-array model. Also drives a LATENCY=1 instance.
module tb_latency_line_memory;

    localparam int LAT = 5;

`ifdef LATENCY_LINE_MEMORY_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;

    logic        req1, ready1, valid1;
    logic [15:0] addr1;
    logic [63:0] rdata1;
    logic        req2, we2, line_we2, ready2, valid2;
    logic [15:0] addr2;
    logic [63:0] wdata2, rdata2;

    logic        req1_b, ready1_b, valid1_b;
    logic [15:0] addr1_b;
    logic [63:0] rdata1_b;
    logic        req2_b, we2_b, line_we2_b, ready2_b, valid2_b;
    logic [15:0] addr2_b;
    logic [63:0] wdata2_b, rdata2_b;

    always #5 clk = ~clk;

    latency_line_memory #(
        .WORD_SIZE(16), .ADDR_WIDTH(16), .DEPTH_LOG2(8), .WORDS_PER_LINE(4), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req1(req1), .addr1(addr1), .ready1(ready1), .valid1(valid1), .rdata1(rdata1),
        .req2(req2), .we2(we2), .line_we2(line_we2), .addr2(addr2), .wdata2(wdata2),
        .ready2(ready2), .valid2(valid2), .rdata2(rdata2)
    );

    latency_line_memory #(
        .WORD_SIZE(16), .ADDR_WIDTH(16), .DEPTH_LOG2(8), .WORDS_PER_LINE(4), .LATENCY(1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .req1(req1_b), .addr1(addr1_b), .ready1(ready1_b), .valid1(valid1_b), .rdata1(rdata1_b),
        .req2(req2_b), .we2(we2_b), .line_we2(line_we2_b), .addr2(addr2_b), .wdata2(wdata2_b),
        .ready2(ready2_b), .valid2(valid2_b), .rdata2(rdata2_b)
    );

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int          lat1, lat2, n1, n2, low1, low2;
        logic [63:0] r1, r2;
    } res_t;

    typedef struct {
        bit          do1;
        logic [15:0] a1;
        bit          do2;
        bit          we;
        bit          lwe;
        logic [15:0] a2;
        logic [63:0] wd;
        logic [63:0] exp1;
        logic [63:0] exp2;
    } vec_t;

    // Reference model: a flat array of 256 words; lines are four consecutive words.
    logic [15:0] model_mem [256];
    logic [63:0] last_r2;

    function automatic logic [63:0] model_line(input logic [15:0] a);
        logic [63:0] l;
        for (int i = 0; i < 4; i++) l[i*16 +: 16] = model_mem[{a[7:2], 2'(i)}];
        return l;
    endfunction

    task automatic model_write(input bit lwe, input logic [15:0] a, input logic [63:0] wd);
        if (lwe) begin
            for (int i = 0; i < 4; i++) model_mem[{a[7:2], 2'(i)}] = wd[i*16 +: 16];
        end else begin
            model_mem[a[7:0]] = wd[15:0];
        end
    endtask

    task automatic check_output(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drives one request per port (optional) at a falling edge and watches LAT+3 cycles.
    task automatic apply_stimulus(input bit do1, input logic [15:0] a1, input bit do2, input bit we,
                                  input bit lwe, input logic [15:0] a2, input logic [63:0] wd,
                                  output res_t res);
        res = '{default: 0};
        req1 = do1; addr1 = a1;
        req2 = do2; we2 = we; line_we2 = lwe; addr2 = a2; wdata2 = wd;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge clk);
            if (valid1) begin
                res.n1++;
                if (res.lat1 == 0) begin res.lat1 = k; res.r1 = rdata1; end
            end
            if (valid2) begin
                res.n2++;
                if (res.lat2 == 0) begin res.lat2 = k; res.r2 = rdata2; end
            end
            if (!ready1) res.low1++;
            if (!ready2) res.low2++;
            if (k == 1) begin
                req1 = 1'b0; req2 = 1'b0;
                addr1 = 16'($urandom); addr2 = 16'($urandom);
                wdata2 = {$urandom, $urandom};
                we2 = 1'($urandom); line_we2 = 1'($urandom);
            end
        end
    endtask

    task automatic check_op(input string tag, input bit do1, input bit do2,
                            input logic [63:0] e1, input logic [63:0] e2, input res_t r);
        if (do1) begin
            check_output({tag, " lat1"}, r.lat1, LAT);
            check_output({tag, " pulses1"}, r.n1, 1);
            check_output({tag, " ready1_low"}, r.low1, LAT - 1);
            check_output({tag, " rdata1"}, r.r1, e1);
        end else begin
            check_output({tag, " pulses1"}, r.n1, 0);
        end
        if (do2) begin
            check_output({tag, " lat2"}, r.lat2, LAT);
            check_output({tag, " pulses2"}, r.n2, 1);
            check_output({tag, " rdata2"}, r.r2, e2);
        end else begin
            check_output({tag, " pulses2"}, r.n2, 0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs [11];
        res_t        r;
        logic [63:0] pre1, pre2, post1, e1, e2, wd, x_line;
        logic [15:0] a1, a2;
        logic [7:0]  hi;
        logic [5:0]  l1, l2;
        bit          do1, do2, we, lwe;
        int          op, n, lat;

        vecs = '{
            '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0010, 64'h4444_3333_2222_1111, 64'h0, 64'h0},
            '{1'b1, 16'h0012, 1'b0, 1'b0, 1'b0, 16'h0000, 64'h0, 64'h4444_3333_2222_1111, 64'h0},
            '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0020, 64'h0004_0003_0002_0001, 64'h0, 64'h0},
            '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0021, 64'hFFFF_FFFF_FFFF_BEEF, 64'h0, 64'h0},
            '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0020, 64'h0, 64'h0, 64'h0004_0003_BEEF_0001},
            '{1'b1, 16'h0110, 1'b0, 1'b0, 1'b0, 16'h0000, 64'h0, 64'h4444_3333_2222_1111, 64'h0},
            '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0013, 64'h1234_5678_9ABC_AAAA, 64'h0, 64'h0},
            '{1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, 64'h0, 64'hAAAA_3333_2222_1111, 64'h0},
            '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hFF10, 64'h0, 64'h0, 64'hAAAA_3333_2222_1111},
            '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0030, 64'h0D0C_0B0A_0908_0706, 64'h0, 64'h0},
            '{1'b1, 16'h0033, 1'b1, 1'b0, 1'b0, 16'h0022, 64'h0, 64'h0D0C_0B0A_0908_0706, 64'h0004_0003_BEEF_0001}
        };

        reset_n = 1'b0;
        req1 = 0; addr1 = 0; req2 = 0; we2 = 0; line_we2 = 0; addr2 = 0; wdata2 = 0;
        req1_b = 0; addr1_b = 0; req2_b = 0; we2_b = 0; line_we2_b = 0; addr2_b = 0; wdata2_b = 0;
        repeat (2) @(negedge clk);
        check_output("reset ready1", ready1, 1);
        check_output("reset ready2", ready2, 1);
        check_output("reset valid1", valid1, 0);
        check_output("reset valid2", valid2, 0);
        check_output("reset rdata1", rdata1, 0);
        check_output("reset rdata2", rdata2, 0);
        reset_n = 1'b1;
        @(negedge clk);
        last_r2 = 64'h0;

        // Fill every line with random data so the model knows the whole array.
        for (int line = 0; line < 64; line++) begin
            wd = {$urandom, $urandom};
            a2 = {8'h00, 6'(line), 2'b00};
            apply_stimulus(1'b0, 16'h0, 1'b1, 1'b1, 1'b1, a2, wd, r);
            model_write(1'b1, a2, wd);
            check_output("init lat2", r.lat2, LAT);
            check_output("init rdata2 held", r.r2, last_r2);
        end

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].do1, vecs[i].a1, vecs[i].do2, vecs[i].we, vecs[i].lwe,
                           vecs[i].a2, vecs[i].wd, r);
            if (vecs[i].do2 && vecs[i].we) model_write(vecs[i].lwe, vecs[i].a2, vecs[i].wd);
            e2 = (vecs[i].do2 && !vecs[i].we) ? vecs[i].exp2 : last_r2;
            check_op($sformatf("vec%0d", i), vecs[i].do1, vecs[i].do2, vecs[i].exp1, e2, r);
            if (vecs[i].do2 && !vecs[i].we) last_r2 = vecs[i].exp2;
        end

        // req1 held high: one acceptance every LAT cycles.
        pre1 = model_line(16'h0050);
        req1 = 1'b1; addr1 = 16'h0050;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k <= 20)
                check_output($sformatf("hold_req valid/ready k=%0d", k), {valid1, ready1},
                             (k % LAT == 0) ? 2'b11 : 2'b00);
            else
                check_output($sformatf("hold_req valid/ready k=%0d", k), {valid1, ready1}, 2'b01);
            if (valid1) check_output("hold_req rdata1", rdata1, pre1);
            if (k == 20) req1 = 1'b0;
        end

        // A second req1 while busy must be dropped.
        pre1 = model_line(16'h0060);
        req1 = 1'b1; addr1 = 16'h0060;
        n = 0; lat = 0; e1 = '0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (valid1) begin
                n++;
                if (lat == 0) begin lat = k; e1 = rdata1; end
            end
            if (k == 1) req1 = 1'b0;
            if (k == 2) begin req1 = 1'b1; addr1 = 16'h0070; end
            if (k == 3) req1 = 1'b0;
        end
        check_output("busy_pulse count", n, 1);
        check_output("busy_pulse lat", lat, LAT);
        check_output("busy_pulse rdata1", e1, pre1);

        // Same-edge completion: port-1 read and port-2 word write on one line.
        wd = 64'hFFFF_0000_FFFF_CAFE;
        pre1 = model_line(16'h0040);
        model_write(1'b0, 16'h0042, wd);
        post1 = model_line(16'h0040);
        apply_stimulus(1'b1, 16'h0041, 1'b1, 1'b1, 1'b0, 16'h0042, wd, r);
        check_op("same_edge word", 1'b1, 1'b1, FWD ? post1 : pre1, last_r2, r);
        wd = {$urandom, $urandom};
        pre1 = model_line(16'h0044);
        model_write(1'b1, 16'h0044, wd);
        apply_stimulus(1'b1, 16'h0047, 1'b1, 1'b1, 1'b1, 16'h0044, wd, r);
        check_op("same_edge line", 1'b1, 1'b1, FWD ? wd : pre1, last_r2, r);
        apply_stimulus(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0, 64'h0, r);
        check_op("same_edge readback", 1'b1, 1'b0, post1, last_r2, r);

        // Reset two cycles into a write: no completion, array untouched.
        pre1 = model_line(16'h0030);
        req2 = 1'b1; we2 = 1'b1; line_we2 = 1'b1; addr2 = 16'h0030; wdata2 = ~pre1;
        @(negedge clk);
        req2 = 1'b0;
        @(negedge clk);
        check_output("reset_mid busy ready2", ready2, 0);
        reset_n = 1'b0;
        #1;
        check_output("reset_mid ready2", ready2, 1);
        check_output("reset_mid valid2", valid2, 0);
        check_output("reset_mid rdata1", rdata1, 0);
        check_output("reset_mid rdata2", rdata2, 0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (valid2) n++;
        end
        check_output("reset_mid no valid2", n, 0);
        last_r2 = 64'h0;
        apply_stimulus(1'b1, 16'h0030, 1'b1, 1'b0, 1'b0, 16'h0031, 64'h0, r);
        check_op("reset_mid readback", 1'b1, 1'b1, pre1, pre1, r);
        last_r2 = pre1;

        // Randomized concurrent traffic, often aimed at the same line.
        for (int it = 0; it < 40; it++) begin
            do1 = ($urandom % 4) != 0;
            do2 = ($urandom % 4) != 0;
            if (!do1 && !do2) do2 = 1'b1;
            l1 = 6'($urandom);
            l2 = ($urandom % 2) ? l1 : 6'($urandom);
            hi = 8'($urandom);
            a1 = {hi, l1, 2'($urandom)};
            hi = 8'($urandom);
            a2 = {hi, l2, 2'($urandom)};
            op = $urandom % 3;
            we = (op != 0);
            lwe = (op == 2);
            wd = {$urandom, $urandom};
            pre1 = model_line(a1);
            pre2 = model_line(a2);
            if (do2 && we) model_write(lwe, a2, wd);
            post1 = model_line(a1);
            e1 = (FWD && do2 && we) ? post1 : pre1;
            e2 = (do2 && !we) ? pre2 : last_r2;
            apply_stimulus(do1, a1, do2, we, lwe, a2, wd, r);
            check_op($sformatf("rand%0d", it), do1, do2, e1, e2, r);
            if (do2 && !we) last_r2 = pre2;
        end

        // LATENCY=1 instance: completion in the cycle right after acceptance.
        x_line = 64'h0123_4567_89AB_CDEF;
        req2_b = 1'b1; we2_b = 1'b1; line_we2_b = 1'b1; addr2_b = 16'h0010; wdata2_b = x_line;
        @(negedge clk);
        check_output("l1 write valid2", valid2_b, 1);
        check_output("l1 write ready2", ready2_b, 1);
        req2_b = 1'b0;
        @(negedge clk);
        check_output("l1 write valid2 drop", valid2_b, 0);
        req1_b = 1'b1; addr1_b = 16'h0110;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check_output($sformatf("l1 b2b valid1 k=%0d", k), valid1_b, 1);
            check_output($sformatf("l1 b2b ready1 k=%0d", k), ready1_b, 1);
            check_output($sformatf("l1 b2b rdata1 k=%0d", k), rdata1_b, x_line);
            if (k == 3) req1_b = 1'b0;
        end
        @(negedge clk);
        check_output("l1 valid1 drop", valid1_b, 0);
        req1_b = 1'b1; addr1_b = 16'h0011;
        req2_b = 1'b1; we2_b = 1'b1; line_we2_b = 1'b0; addr2_b = 16'h0012; wdata2_b = 64'h0000_0000_0000_5555;
        @(negedge clk);
        req1_b = 1'b0; req2_b = 1'b0;
        check_output("l1 same_edge rdata1", rdata1_b, FWD ? 64'h0123_5555_89AB_CDEF : x_line);
        req1_b = 1'b1; addr1_b = 16'h0010;
        @(negedge clk);
        req1_b = 1'b0;
        check_output("l1 readback rdata1", rdata1_b, 64'h0123_5555_89AB_CDEF);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
